// File: rtl/mul32_seqref_chk_pkg.sv
//------------------------------------------------------------------------------
// Module  : mul32_seqref_chk_pkg
// Brief   : Shared types, defaults and helpers for the serial product checker.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mul32_seqref_chk_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_CMP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_MUL  = ST_MUL,
    S_CMP  = ST_CMP
  } state_e;

  // Saturating increment of the low w bits of v (1 <= w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul32_seqref_chk_if.sv
//------------------------------------------------------------------------------
// Module  : mul32_seqref_chk_if
// Brief   : Transaction and status bundle of the checker.
//           Capture signals exist only with MUL32_CHK_CAPTURE_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mul32_seqref_chk_if
  import mul32_seqref_chk_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [2*WIDTH-1:0]   in_p;
  logic [CNT_W-1:0]     err_count;
  logic [CNT_W-1:0]     chk_count;
  logic                 chk_done;
  logic                 mismatch;
`ifdef MUL32_CHK_CAPTURE_EN
  logic [WIDTH-1:0]     cap_a;
  logic [WIDTH-1:0]     cap_b;
  logic [2*WIDTH-1:0]   cap_p;
  logic [2*WIDTH-1:0]   cap_exp;
  logic                 cap_vld;

  modport master (
    output in_valid, in_a, in_b, in_p,
    input  in_ready, err_count, chk_count, chk_done, mismatch,
    input  cap_a, cap_b, cap_p, cap_exp, cap_vld
  );

  modport slave (
    input  in_valid, in_a, in_b, in_p,
    output in_ready, err_count, chk_count, chk_done, mismatch,
    output cap_a, cap_b, cap_p, cap_exp, cap_vld
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_p,
    input  in_ready, err_count, chk_count, chk_done, mismatch
  );

  modport slave (
    input  in_valid, in_a, in_b, in_p,
    output in_ready, err_count, chk_count, chk_done, mismatch
  );
`endif

endinterface

`default_nettype wire

// File: rtl/mul32_shift_add_core.sv
//------------------------------------------------------------------------------
// Module  : mul32_shift_add_core
// Brief   : Serial shift-add multiplier, one multiplier bit per cycle.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul32_shift_add_core #(
  parameter int unsigned WIDTH = 32
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 start_i,
  input  wire logic [WIDTH-1:0]     a_i,
  input  wire logic [WIDTH-1:0]     b_i,
  output logic                      busy_o,
  output logic                      last_o,
  output logic [2*WIDTH-1:0]        acc_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [2*WIDTH-1:0] acc_q,  acc_d;
  logic [CW-1:0]      cnt_q,  cnt_d;
  logic               busy_q, busy_d;
  logic               w_last;

  assign w_last = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      a_sh_d = {{WIDTH{1'b0}}, a_i};
      b_sh_d = b_i;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (b_sh_q[0]) begin
        acc_d = acc_q + a_sh_q;
      end
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      cnt_d  = cnt_q + 1'b1;
      if (w_last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign last_o = w_last;
  assign acc_o  = acc_q;

endmodule

`default_nettype wire

// File: rtl/mul32_seqref_chk.sv
//------------------------------------------------------------------------------
// Module  : mul32_seqref_chk
// Brief   : Recomputes a*b serially and compares it with the received product.
//           Optional first-mismatch capture: MUL32_CHK_CAPTURE_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul32_seqref_chk
  import mul32_seqref_chk_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input wire logic          clk,
  input wire logic          rst,
  mul32_seqref_chk_if.slave bus
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] p_cap_q, p_cap_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   chk_q, chk_d;
  logic               done_q, done_d;
  logic               mis_q, mis_d;
  logic               w_start, w_busy, w_last, w_mis;
  logic [2*WIDTH-1:0] w_acc;

  mul32_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start_i (w_start),
    .a_i     (bus.in_a),
    .b_i     (bus.in_b),
    .busy_o  (w_busy),
    .last_o  (w_last),
    .acc_o   (w_acc)
  );

  assign w_mis = (w_acc != p_cap_q);

  always_comb begin
    state_d = state_q;
    w_start = 1'b0;
    p_cap_d = p_cap_q;
    err_d   = err_q;
    chk_d   = chk_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !w_busy) begin
          w_start = 1'b1;
          p_cap_d = bus.in_p;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (w_last) begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        done_d  = 1'b1;
        mis_d   = w_mis;
        chk_d   = CNT_W'(sat_inc(64'(chk_q), CNT_W));
        if (w_mis) begin
          err_d = CNT_W'(sat_inc(64'(err_q), CNT_W));
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_cap_q <= '0;
      err_q   <= '0;
      chk_q   <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_cap_q <= p_cap_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !w_busy;
  assign bus.err_count = err_q;
  assign bus.chk_count = chk_q;
  assign bus.chk_done  = done_q;
  assign bus.mismatch  = mis_q;

`ifdef MUL32_CHK_CAPTURE_EN
  // Operands are destroyed by the shifter, so keep a copy for the capture.
  logic [WIDTH-1:0]   op_a_q, op_b_q;
  logic [WIDTH-1:0]   cap_a_q, cap_b_q;
  logic [2*WIDTH-1:0] cap_p_q, cap_exp_q;
  logic               cap_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      cap_a_q   <= '0;
      cap_b_q   <= '0;
      cap_p_q   <= '0;
      cap_exp_q <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      if (w_start) begin
        op_a_q <= bus.in_a;
        op_b_q <= bus.in_b;
      end
      if ((state_q == S_CMP) && w_mis && !cap_vld_q) begin
        cap_a_q   <= op_a_q;
        cap_b_q   <= op_b_q;
        cap_p_q   <= p_cap_q;
        cap_exp_q <= w_acc;
        cap_vld_q <= 1'b1;
      end
    end
  end

  assign bus.cap_a   = cap_a_q;
  assign bus.cap_b   = cap_b_q;
  assign bus.cap_p   = cap_p_q;
  assign bus.cap_exp = cap_exp_q;
  assign bus.cap_vld = cap_vld_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul32_seqref_chk.sv
//------------------------------------------------------------------------------
// Module  : tb_mul32_seqref_chk
// Brief   : Directed self-checking bench with a cycle-level reference model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul32_seqref_chk;
  import mul32_seqref_chk_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul32_seqref_chk_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  mul32_seqref_chk_if #(.WIDTH(W), .CNT_W(4))  bus2 ();

  mul32_seqref_chk #(.WIDTH(W), .CNT_W(CW)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mul32_seqref_chk #(.WIDTH(W), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a transaction accepted while free completes WIDTH+1 edges later.
  int              m_left = 0;
  logic            m_pend = 1'b0;
  logic            m_done = 1'b0;
  logic            m_mis  = 1'b0;
  logic [CW-1:0]   m_err  = '0;
  logic [CW-1:0]   m_chk  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_mis  <= 1'b0;
      m_err  <= '0;
      m_chk  <= '0;
    end else begin
      m_done <= 1'b0;
      m_mis  <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_mis  <= m_pend;
          if (m_chk != '1) m_chk <= m_chk + 1'b1;
          if (m_pend && m_err != '1) m_err <= m_err + 1'b1;
        end
      end else if (bus.in_valid) begin
        m_pend <= (64'(bus.in_a) * 64'(bus.in_b)) != bus.in_p;
        m_left <= int'(W) + 1;
      end
    end
  end

  logic cmp_en    = 1'b0;
  int   done_seen = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",  64'(bus.in_ready),  64'(m_left == 0));
      check("chk_done",  64'(bus.chk_done),  64'(m_done));
      check("mismatch",  64'(bus.mismatch),  64'(m_mis));
      check("err_count", 64'(bus.err_count), 64'(m_err));
      check("chk_count", 64'(bus.chk_count), 64'(m_chk));
      if (bus.chk_done) done_seen++;
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
    bus.in_a = a; bus.in_b = b; bus.in_p = p; bus.in_valid = 1'b1;
    for (int k = 0; k < 100 && !bus.in_ready; k++) @(negedge clk);
    check("send_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // lat = rising edges from handshake to the first edge that samples chk_done high.
  task automatic wait_done(output int lat);
    int k;
    k = 0;
    while (k < 100 && !bus.chk_done) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", 64'(bus.chk_done), 64'd1);
    lat = k + 1;
  endtask

  task automatic send2(input logic [31:0] a, input logic [63:0] p);
    int k;
    bus2.in_a = a; bus2.in_b = 32'd1; bus2.in_p = p; bus2.in_valid = 1'b1;
    for (int j = 0; j < 100 && !bus2.in_ready; j++) @(negedge clk);
    check("send2_ready", 64'(bus2.in_ready), 64'd1);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    k = 0;
    while (k < 100 && !bus2.chk_done) begin
      @(negedge clk);
      k++;
    end
    check("done2_timeout", 64'(bus2.chk_done), 64'd1);
  endtask

  initial begin
    int lat, run, nruns, hs, d0;
    logic [31:0] ra, rb;
    bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.in_p = '0;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_p = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_chk_done",  64'(bus.chk_done),  64'd0);
    check("rst_mismatch",  64'(bus.mismatch),  64'd0);
    check("rst_err_count", 64'(bus.err_count), 64'd0);
    check("rst_chk_count", 64'(bus.chk_count), 64'd0);
    cmp_en = 1'b1;

    // 3 x 5 = 15
    send(32'd3, 32'd5, 64'd15);
    wait_done(lat);
    check("t1_latency",   64'(lat),           64'd34);
    check("t1_mismatch",  64'(bus.mismatch),  64'd0);
    check("t1_chk_count", 64'(bus.chk_count), 64'd1);
    check("t1_err_count", 64'(bus.err_count), 64'd0);

    // Full-scale operands, correct then off-by-one product.
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done(lat);
    check("t2_good_mismatch", 64'(bus.mismatch), 64'd0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0000);
    wait_done(lat);
    check("t2_bad_mismatch",  64'(bus.mismatch),  64'd1);
    check("t2_err_count",     64'(bus.err_count), 64'd1);
    check("t2_chk_count",     64'(bus.chk_count), 64'd3);

    // Streaming: valid held high, fresh pair every cycle.
    run = 0; nruns = 0; hs = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 110; i++) begin
      if (bus.in_ready) hs++;
      ra = $urandom; rb = $urandom;
      bus.in_a = ra; bus.in_b = rb;
      bus.in_p = (i % 3 == 0) ? (64'(ra) * 64'(rb)) + 64'd1 : 64'(ra) * 64'(rb);
      @(negedge clk);
      if (!bus.in_ready) run++;
      else if (run > 0) begin
        check("t3_ready_low_run", 64'(run), 64'd33);
        run = 0;
        nruns++;
      end
    end
    bus.in_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("t3_runs_seen",  64'(nruns >= 3),    64'd1);
    check("t3_chk_count",  64'(bus.chk_count), 64'(3 + hs));

    // Reset in the middle of a mismatching check.
    send(32'd7, 32'd9, 64'd0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_in_ready",  64'(bus.in_ready),  64'd1);
    check("t4_err_count", 64'(bus.err_count), 64'd0);
    check("t4_chk_count", 64'(bus.chk_count), 64'd0);
    d0 = done_seen;
    repeat (40) @(negedge clk);
    check("t4_no_done", 64'(done_seen - d0), 64'd0);

`ifdef MUL32_CHK_CAPTURE_EN
    send(32'd2, 32'd3, 64'd7);
    wait_done(lat);
    check("cap_vld", 64'(bus.cap_vld), 64'd1);
    check("cap_a",   64'(bus.cap_a),   64'd2);
    check("cap_b",   64'(bus.cap_b),   64'd3);
    check("cap_p",   bus.cap_p,        64'd7);
    check("cap_exp", bus.cap_exp,      64'd6);
    send(32'h10, 32'h10, 64'd0);
    wait_done(lat);
    check("cap2_mismatch", 64'(bus.mismatch), 64'd1);
    check("cap2_vld", 64'(bus.cap_vld), 64'd1);
    check("cap2_a",   64'(bus.cap_a),   64'd2);
    check("cap2_b",   64'(bus.cap_b),   64'd3);
    check("cap2_p",   bus.cap_p,        64'd7);
    check("cap2_exp", bus.cap_exp,      64'd6);
`endif

    // 4-bit counters saturate at 15.
    for (int i = 0; i < 20; i++) begin
      send2(32'(i + 1), 64'd0);
      check("sat_err_count", 64'(bus2.err_count), 64'((i + 1 > 15) ? 15 : i + 1));
      check("sat_chk_count", 64'(bus2.chk_count), 64'((i + 1 > 15) ? 15 : i + 1));
    end
    repeat (5) @(negedge clk);
    check("sat_err_final", 64'(bus2.err_count), 64'd15);
    check("sat_chk_final", 64'(bus2.chk_count), 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
